// File: rtl/layer_compositor.sv
`default_nettype none
// ============================================================================
// Module   : layer_compositor
// Purpose  : Priority compositor of object layers over a background code,
//            with a frame-based flash timer and 8-bit VGA colour expansion.
// Revision : 1.0
// ============================================================================
module layer_compositor #(
    parameter int          NUM_LAYERS   = 8,
    parameter logic [1:0]  ACTIVE_MODE  = 2'b10,
    parameter int          FLASH_FRAMES = 8,
    parameter int          LIDX_W       = $clog2(NUM_LAYERS)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_start,
    input  logic [1:0]            mode,
    input  logic                  pix_valid,
    input  logic [NUM_LAYERS-1:0] layer_hit,
    input  logic [11:0]           bg_code,
    input  logic                  cfg_we,
    input  logic [LIDX_W-1:0]     cfg_addr,
    input  logic [13:0]           cfg_data,
    output logic [7:0]            VGA_R,
    output logic [7:0]            VGA_G,
    output logic [7:0]            VGA_B,
    output logic                  pix_valid_out,
    output logic [LIDX_W:0]       sel_layer
);

    localparam int                c_FCNT_W    = $clog2(FLASH_FRAMES) + 1;
    localparam logic [c_FCNT_W-1:0] c_FCNT_LAST = c_FCNT_W'(FLASH_FRAMES - 1);
    localparam logic [LIDX_W:0]   c_BG_SEL    = (LIDX_W + 1)'(NUM_LAYERS);

    logic [NUM_LAYERS-1:0] r_en;
    logic [NUM_LAYERS-1:0] r_fl;
    logic [11:0]           r_code [NUM_LAYERS];

    logic [c_FCNT_W-1:0]   r_fcnt;
    logic                  r_phase;

    logic                  r_s1_valid;
    logic [LIDX_W:0]       r_s1_sel;
    logic [11:0]           r_s1_code;

    logic [7:0]            r_vga_r;
    logic [7:0]            r_vga_g;
    logic [7:0]            r_vga_b;
    logic                  r_valid_out;
    logic [LIDX_W:0]       r_sel_out;

    logic                  w_cfg_ok;
    logic [NUM_LAYERS-1:0] w_hit;
    logic [LIDX_W:0]       w_sel;
    logic [11:0]           w_code;

    assign w_cfg_ok = cfg_we && ({1'b0, cfg_addr} < c_BG_SEL);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_en <= '0;
            r_fl <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                r_code[i] <= 12'h000;
            end
        end else if (w_cfg_ok) begin
            r_en[cfg_addr]   <= cfg_data[13];
            r_fl[cfg_addr]   <= cfg_data[12];
            r_code[cfg_addr] <= cfg_data[11:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fcnt  <= '0;
            r_phase <= 1'b1;
        end else if (frame_start) begin
            if (r_fcnt == c_FCNT_LAST) begin
                r_fcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_fcnt  <= r_fcnt + c_FCNT_W'(1);
            end
        end
    end

    assign w_hit = layer_hit & r_en & (~r_fl | {NUM_LAYERS{r_phase}})
                 & {NUM_LAYERS{mode == ACTIVE_MODE}};

    // Scan from lowest priority upward so the lowest set index ends up winning.
    always_comb begin
        w_sel  = c_BG_SEL;
        w_code = bg_code;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_sel  = (LIDX_W + 1)'(i);
                w_code = r_code[i];
            end
        end
    end

    // The winning code is snapshotted here, so a table write in the following
    // cycle cannot recolour a pixel that is already in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sel   <= c_BG_SEL;
            r_s1_code  <= 12'h000;
        end else begin
            r_s1_valid <= pix_valid;
            r_s1_sel   <= w_sel;
            r_s1_code  <= w_code;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_vga_r     <= 8'h00;
            r_vga_g     <= 8'h00;
            r_vga_b     <= 8'h00;
            r_valid_out <= 1'b0;
            r_sel_out   <= c_BG_SEL;
        end else begin
            r_vga_r     <= r_s1_valid ? {r_s1_code[11:8], r_s1_code[11:8]} : 8'h00;
            r_vga_g     <= r_s1_valid ? {r_s1_code[7:4],  r_s1_code[7:4]}  : 8'h00;
            r_vga_b     <= r_s1_valid ? {r_s1_code[3:0],  r_s1_code[3:0]}  : 8'h00;
            r_valid_out <= r_s1_valid;
            r_sel_out   <= r_s1_sel;
        end
    end

    assign VGA_R         = r_vga_r;
    assign VGA_G         = r_vga_g;
    assign VGA_B         = r_vga_b;
    assign pix_valid_out = r_valid_out;
    assign sel_layer     = r_sel_out;

endmodule
`default_nettype wire

// File: tb/tb_layer_compositor.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_compositor
// Purpose  : Directed and randomized checks of layer_compositor against a
//            frame-counting reference model with a two-pixel expectation queue.
// Revision : 1.0
// ============================================================================
module tb_layer_compositor;

    localparam int         NL = 6;
    localparam int         LW = 3;
    localparam int         FF = 2;
    localparam logic [1:0] AM = 2'b10;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          frame_start;
    logic [1:0]    mode;
    logic          pix_valid;
    logic [NL-1:0] layer_hit;
    logic [11:0]   bg_code;
    logic          cfg_we;
    logic [LW-1:0] cfg_addr;
    logic [13:0]   cfg_data;
    logic [7:0]    VGA_R;
    logic [7:0]    VGA_G;
    logic [7:0]    VGA_B;
    logic          pix_valid_out;
    logic [LW:0]   sel_layer;

    layer_compositor #(
        .NUM_LAYERS   (NL),
        .ACTIVE_MODE  (AM),
        .FLASH_FRAMES (FF),
        .LIDX_W       (LW)
    ) u_dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_start   (frame_start),
        .mode          (mode),
        .pix_valid     (pix_valid),
        .layer_hit     (layer_hit),
        .bg_code       (bg_code),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .VGA_R         (VGA_R),
        .VGA_G         (VGA_G),
        .VGA_B         (VGA_B),
        .pix_valid_out (pix_valid_out),
        .sel_layer     (sel_layer)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [23:0] rgb;
        logic [LW:0] sel;
        logic        v;
    } exp_t;

    exp_t        q[$];
    bit          m_en [NL];
    bit          m_fl [NL];
    logic [11:0] m_code [NL];
    int          nframes;
    int          n_checks;
    int          n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    endtask

    function automatic logic [7:0] exp8(input logic [3:0] n);
        return 8'(int'(n) * 17);
    endfunction

    function automatic exp_t reset_entry();
        exp_t e;
        e.rgb = 24'h0;
        e.sel = (LW + 1)'(NL);
        e.v   = 1'b0;
        return e;
    endfunction

    // Visibility is derived from the number of frames seen since reset.
    function automatic exp_t model_pixel(input logic [1:0] md, input logic pv,
                                         input logic [NL-1:0] hit, input logic [11:0] bg);
        exp_t        e;
        int          win  = NL;
        logic [11:0] code = bg;
        bit          vis  = ((nframes / FF) % 2) == 0;
        if (md == AM) begin
            for (int i = 0; i < NL; i++) begin
                if (win == NL && hit[i] && m_en[i] && (!m_fl[i] || vis)) begin
                    win  = i;
                    code = m_code[i];
                end
            end
        end
        e.sel = (LW + 1)'(win);
        e.v   = pv;
        e.rgb = pv ? {exp8(code[11:8]), exp8(code[7:4]), exp8(code[3:0])} : 24'h0;
        return e;
    endfunction

    task automatic cycle(input logic rst, input logic fs, input logic [1:0] md, input logic pv,
                         input logic [NL-1:0] hit, input logic [11:0] bg,
                         input logic we, input logic [LW-1:0] addr, input logic [13:0] data);
        exp_t e;
        Reset = rst; frame_start = fs; mode = md; pix_valid = pv;
        layer_hit = hit; bg_code = bg; cfg_we = we; cfg_addr = addr; cfg_data = data;
        if (rst) begin
            q.delete();
            q.push_back(reset_entry());
            q.push_back(reset_entry());
            nframes = 0;
            for (int i = 0; i < NL; i++) begin
                m_en[i] = 0; m_fl[i] = 0; m_code[i] = 12'h000;
            end
        end else begin
            q.push_back(model_pixel(md, pv, hit, bg));
            if (we && int'(addr) < NL) begin
                m_en[addr]   = data[13];
                m_fl[addr]   = data[12];
                m_code[addr] = data[11:0];
            end
            if (fs) nframes++;
        end
        @(posedge Clk);
        @(negedge Clk);
        e = q.pop_front();
        check("rgb",   32'({VGA_R, VGA_G, VGA_B}), 32'(e.rgb));
        check("sel",   32'(sel_layer),             32'(e.sel));
        check("valid", 32'(pix_valid_out),         32'(e.v));
    endtask

    task automatic pix(input logic [1:0] md, input logic pv, input logic [NL-1:0] hit,
                       input logic [11:0] bg);
        cycle(1'b0, 1'b0, md, pv, hit, bg, 1'b0, '0, 14'h0);
    endtask

    task automatic cfg(input logic [LW-1:0] addr, input logic [13:0] data);
        cycle(1'b0, 1'b0, AM, 1'b1, '0, 12'h124, 1'b1, addr, data);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        nframes  = 0;

        cycle(1'b1, 1'b0, AM, 1'b1, '1, 12'hfff, 1'b0, '0, 14'h0);
        cycle(1'b1, 1'b0, AM, 1'b1, '1, 12'hfff, 1'b0, '0, 14'h0);
        for (int i = 0; i < 4; i++) pix(AM, 1'b1, '0, 12'h124);

        cfg(3'd0, 14'h2ccc);
        cfg(3'd3, 14'h2fff);
        for (int i = 0; i < 3; i++) pix(AM, 1'b1, 6'b001001, 12'h124);
        for (int i = 0; i < 3; i++) pix(AM, 1'b1, 6'b001000, 12'h124);
        for (int i = 0; i < 3; i++) pix(2'b01, 1'b1, 6'b001001, 12'h3a5);

        cfg(3'd2, 14'h3f00);
        for (int f = 0; f < 9; f++) begin
            cycle(1'b0, 1'b1, AM, 1'b1, 6'b000100, 12'h0f0, 1'b0, '0, 14'h0);
            pix(AM, 1'b1, 6'b000100, 12'h0f0);
            pix(AM, 1'b1, 6'b000100, 12'h0f0);
        end

        pix(AM, 1'b1, 6'b000010, 12'h00f);
        cycle(1'b0, 1'b0, AM, 1'b1, 6'b000010, 12'h00f, 1'b1, 3'd1, 14'h20f0);
        for (int i = 0; i < 3; i++) pix(AM, 1'b1, 6'b000010, 12'h00f);

        pix(AM, 1'b1, 6'b001010, 12'h555);
        pix(AM, 1'b0, 6'b001010, 12'h555);
        for (int i = 0; i < 3; i++) pix(AM, 1'b1, 6'b001010, 12'h555);

        cfg(3'd6, 14'h2abc);
        cfg(3'd7, 14'h3123);
        for (int i = 0; i < 3; i++) pix(AM, 1'b1, 6'b110000, 12'h777);

        pix(AM, 1'b1, 6'b111111, 12'h246);
        cycle(1'b1, 1'b0, AM, 1'b1, 6'b111111, 12'h246, 1'b0, '0, 14'h0);
        for (int i = 0; i < 4; i++) pix(AM, 1'b1, 6'b111111, 12'h246);

        for (int n = 0; n < 400; n++) begin
            logic          rst, fs, pv, we;
            logic [1:0]    md;
            logic [NL-1:0] hit;
            logic [11:0]   bg;
            logic [LW-1:0] addr;
            logic [13:0]   data;
            rst  = ($urandom_range(0, 63) == 0);
            fs   = ($urandom_range(0, 4) == 0);
            md   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : AM;
            pv   = ($urandom_range(0, 7) != 0);
            hit  = NL'($urandom);
            bg   = 12'($urandom);
            we   = ($urandom_range(0, 3) == 0);
            addr = LW'($urandom);
            data = 14'($urandom);
            cycle(rst, fs, md, pv, hit, bg, we, addr, data);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
